// File: rtl/pipe_mem_arb.sv
// Single-port memory arbiter sharing one fixed-latency memory between IF and MEM stages.
// Define PIPE_MEM_ARB_FAIR_EN to alternate winners under contention (default: fixed DM priority).
module pipe_mem_arb #(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_dm
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       we_q, we_nxt;
  logic       done, rv_if, rv_dm, pend_if, pend_dm;
  logic       grant, pick_dm, gnt_if_w, gnt_dm_w;

  assign done  = (state != IDLE) && (cnt == 3'd1);
  assign rv_if = done && (state == BUSY_IF);
  assign rv_dm = done && (state == BUSY_DM);

  // A requester whose transaction completes this cycle is not asking for another one yet.
  assign pend_if = if_req && !rv_if;
  assign pend_dm = dm_req && !rv_dm;

`ifdef PIPE_MEM_ARB_FAIR_EN
  logic last_dm;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)         last_dm <= 1'b0;
    else if (gnt_dm_w) last_dm <= 1'b1;
    else if (gnt_if_w) last_dm <= 1'b0;
  end

  assign pick_dm = pend_dm && !(pend_if && last_dm);
`else
  assign pick_dm = pend_dm;
`endif

  // NOTE: clrn gates the combinational grant so every output reads 0 while reset is held.
  assign grant    = clrn && ((state == IDLE) || done) && (pend_if || pend_dm);
  assign gnt_dm_w = grant && pick_dm;
  assign gnt_if_w = grant && !pick_dm;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
      cnt   <= 3'd0;
      we_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      we_q  <= we_nxt;
    end
  end

  // NOTE: defaults at the top of each always_comb keep every path assigned, so no latches.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    we_nxt    = we_q;
    if (grant) begin
      state_nxt = gnt_dm_w ? BUSY_DM : BUSY_IF;
      cnt_nxt   = LAT;
      we_nxt    = gnt_dm_w && dm_we;
    end else if (done) begin
      state_nxt = IDLE;
      cnt_nxt   = 3'd0;
    end else if (state != IDLE) begin
      cnt_nxt = cnt - 3'd1;
    end
  end

  always_comb begin
    if_gnt    = gnt_if_w;
    dm_gnt    = gnt_dm_w;
    mem_en    = grant;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    if_rvalid = rv_if;
    dm_rvalid = rv_dm;
    if_rdata  = 32'h0;
    dm_rdata  = 32'h0;
    stall_if  = clrn && pend_if;
    stall_dm  = clrn && pend_dm;
    if (gnt_dm_w) begin
      mem_we    = dm_we;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (gnt_if_w) begin
      mem_addr = if_addr;
    end
    if (rv_if)          if_rdata = mem_rdata;
    if (rv_dm && !we_q) dm_rdata = mem_rdata;
  end

endmodule

// File: tb/tb_pipe_mem_arb.sv
// Bench for pipe_mem_arb: directed scenarios plus random traffic against a transaction-level model.
// A second instance with MEM_LAT=3 exercises reset during a longer access.
module tb_pipe_mem_arb;
  localparam int LAT = 2;
`ifdef PIPE_MEM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clrn, env_rst_n;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, stall_if, stall_dm;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_gnt_3, if_rvalid_3, dm_gnt_3, dm_rvalid_3, mem_en_3, mem_we_3, stall_if_3, stall_dm_3;
  logic [31:0] if_rdata_3, dm_rdata_3, mem_addr_3, mem_wdata_3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_mem_arb #(.MEM_LAT(LAT)) u_dut (
    .clk(clk), .clrn(clrn),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_dm(stall_dm)
  );

  pipe_mem_arb #(.MEM_LAT(3)) u_lat3 (
    .clk(clk), .clrn(clrn),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_3), .if_rvalid(if_rvalid_3), .if_rdata(if_rdata_3),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt_3), .dm_rvalid(dm_rvalid_3), .dm_rdata(dm_rdata_3),
    .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3),
    .mem_rdata(mem_rdata), .stall_if(stall_if_3), .stall_dm(stall_dm_3)
  );

  function automatic logic [31:0] init_val(input logic [7:0] idx);
    if (idx == 8'd16) return 32'h8C01_0004;
    return {idx, 24'h0} ^ ({24'h0, idx} * 32'h9E37_79B9) ^ 32'h1357_9BDF;
  endfunction

  // Memory environment: word-indexed store, read data delivered LAT cycles after mem_en.
  logic [31:0]  env_mem [256];
  logic [255:0] written;
  logic [31:0]  rd_pipe [8];

  function automatic logic [31:0] env_rd(input logic [31:0] a);
    return written[a[9:2]] ? env_mem[a[9:2]] : init_val(a[9:2]);
  endfunction

  always @(posedge clk or negedge env_rst_n) begin
    if (!env_rst_n) begin
      written <= '0;
      for (int i = 0; i < 8; i++) rd_pipe[i] <= 32'h0;
    end else begin
      if (mem_en && mem_we) begin
        env_mem[mem_addr[9:2]] <= mem_wdata;
        written[mem_addr[9:2]] <= 1'b1;
      end
      rd_pipe[0] <= mem_en ? (mem_we ? 32'hBAD0_57E0 : env_rd(mem_addr)) : 32'hFACE_0FF0;
      for (int i = 1; i < 8; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end
  assign mem_rdata = rd_pipe[LAT-1];

  // Reference model: one transaction at a time, finishing exactly LAT cycles after its grant.
  logic [31:0]  model_mem [256];
  logic         m_busy, m_dm, m_last_dm;
  logic [31:0]  m_data;
  int           m_done, cyc;
  logic [7:0]   e_flags;  // {if_gnt, dm_gnt, mem_en, mem_we, if_rvalid, dm_rvalid, stall_if, stall_dm}
  logic [127:0] e_data;   // {mem_addr, mem_wdata, if_rdata, dm_rdata}

  task automatic model_eval();
    logic comp, irv, drv, pi, pd, g, wdm, gi, gd;
    comp = clrn && m_busy && (cyc == m_done);
    irv  = comp && !m_dm;
    drv  = comp && m_dm;
    pi   = if_req && !irv;
    pd   = dm_req && !drv;
    g    = clrn && (!m_busy || comp) && (pi || pd);
    wdm  = pd && !(FAIR && pi && m_last_dm);
    gd   = g && wdm;
    gi   = g && !wdm;
    e_flags = {gi, gd, g, gd && dm_we, irv, drv, clrn && pi, clrn && pd};
    e_data  = {gd ? dm_addr : (gi ? if_addr : 32'h0), gd ? dm_wdata : 32'h0,
               irv ? m_data : 32'h0, drv ? m_data : 32'h0};
  endtask

  task automatic model_commit();
    logic [31:0] a;
    a = e_data[127:96];
    if (!clrn) begin
      m_busy    = 1'b0;
      m_last_dm = 1'b0;
    end else if (e_flags[5]) begin
      m_busy    = 1'b1;
      m_dm      = e_flags[6];
      m_last_dm = e_flags[6];
      m_done    = cyc + LAT;
      if (e_flags[4]) begin
        model_mem[a[9:2]] = dm_wdata;
        m_data = 32'h0;
      end else begin
        m_data = model_mem[a[9:2]];
      end
    end else if (e_flags[3] || e_flags[2]) begin
      m_busy = 1'b0;
    end
    cyc++;
  endtask

  function automatic logic [7:0] obs_flags();
    return {if_gnt, dm_gnt, mem_en, mem_we, if_rvalid, dm_rvalid, stall_if, stall_dm};
  endfunction

  // Read data is only meaningful on a response pulse or while reset is held.
  function automatic logic [127:0] obs_data();
    return {mem_addr, mem_wdata, (e_flags[3] || !clrn) ? if_rdata : 32'h0,
            (e_flags[2] || !clrn) ? dm_rdata : 32'h0};
  endfunction

  task automatic set_idle();
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = 32'h0; dm_addr = 32'h0; dm_wdata = 32'h0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 8; k++) begin
      set_idle();
      case (k)
        0: begin clrn = 1'b0; if_req = 1'b1; dm_req = 1'b1; end
        1: begin clrn = 1'b1; dm_req = 1'b1; dm_addr = 32'h80; end
        2: begin clrn = 1'b0; if_req = 1'b1; dm_req = 1'b1; dm_addr = 32'h80; end
        3: begin clrn = 1'b1; if_req = 1'b1; if_addr = 32'h20; end
        default: clrn = 1'b1;
      endcase
      model_eval();
      @(negedge clk);
      vectors++;
      if (obs_flags() !== e_flags) begin
        miscompares++;
        $display("FAIL reset flags k=%0d got=%b exp=%b", k, obs_flags(), e_flags);
      end
      vectors++;
      if (obs_data() !== e_data) begin
        miscompares++;
        $display("FAIL reset data k=%0d got=%h exp=%h", k, obs_data(), e_data);
      end
      if (k == 0 || k == 2) begin
        vectors++;
        if ({if_gnt_3, if_rvalid_3, dm_gnt_3, dm_rvalid_3, mem_en_3, mem_we_3, stall_if_3, stall_dm_3,
             if_rdata_3, dm_rdata_3, mem_addr_3, mem_wdata_3} !== 136'h0) begin
          miscompares++;
          $display("FAIL reset lat3_outputs_zero k=%0d got gnt=%b%b en=%b stall=%b%b addr=%h exp all 0",
                   k, if_gnt_3, dm_gnt_3, mem_en_3, stall_if_3, stall_dm_3, mem_addr_3);
        end
      end
      if (k == 3) begin
        vectors++;
        if (if_gnt_3 !== 1'b1) begin
          miscompares++;
          $display("FAIL reset lat3_if_gnt_after_release got=%b exp=1", if_gnt_3);
        end
      end
      if (k >= 1) begin
        vectors++;
        if (dm_rvalid_3 !== 1'b0) begin
          miscompares++;
          $display("FAIL reset lat3_no_dm_rvalid k=%0d got=%b exp=0", k, dm_rvalid_3);
        end
      end
      if (k == 6) begin
        vectors++;
        if (if_rvalid_3 !== 1'b1) begin
          miscompares++;
          $display("FAIL reset lat3_if_rvalid got=%b exp=1", if_rvalid_3);
        end
      end
      model_commit();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_single_fetch();
    for (int k = 0; k < 4; k++) begin
      set_idle();
      if (k < 3) begin if_req = 1'b1; if_addr = 32'h40; end
      model_eval();
      @(negedge clk);
      vectors++;
      if (obs_flags() !== e_flags || obs_data() !== e_data) begin
        miscompares++;
        $display("FAIL fetch model k=%0d got=%b/%h exp=%b/%h", k, obs_flags(), obs_data(), e_flags, e_data);
      end
      if (k == 0) begin
        vectors++;
        if ({if_gnt, mem_en, mem_we, mem_addr} !== {1'b1, 1'b1, 1'b0, 32'h40}) begin
          miscompares++;
          $display("FAIL fetch grant got gnt=%b en=%b we=%b addr=%h exp 1 1 0 00000040",
                   if_gnt, mem_en, mem_we, mem_addr);
        end
      end
      if (k < 2) begin
        vectors++;
        if (stall_if !== 1'b1) begin
          miscompares++;
          $display("FAIL fetch stall_if k=%0d got=%b exp=1", k, stall_if);
        end
      end
      if (k == 2) begin
        vectors++;
        if ({if_rvalid, if_rdata} !== {1'b1, 32'h8C01_0004}) begin
          miscompares++;
          $display("FAIL fetch response got rvalid=%b rdata=%h exp 1 8c010004", if_rvalid, if_rdata);
        end
      end
      model_commit();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_contention();
    int ng = 0;
    for (int k = 0; k < 14; k++) begin
      set_idle();
      if_req = (k <= 12); if_addr = 32'h200;
      dm_req = (k <= 10); dm_addr = 32'h300;
      model_eval();
      @(negedge clk);
      vectors++;
      if (obs_flags() !== e_flags || obs_data() !== e_data) begin
        miscompares++;
        $display("FAIL contention model k=%0d got=%b/%h exp=%b/%h", k, obs_flags(), obs_data(), e_flags, e_data);
      end
      if (if_gnt || dm_gnt) begin
        vectors++;
        if ({dm_gnt, if_gnt} !== ((ng % 2 == 0) ? 2'b10 : 2'b01)) begin
          miscompares++;
          $display("FAIL contention order grant#%0d got dm/if=%b%b exp %s", ng, dm_gnt, if_gnt,
                   (ng % 2 == 0) ? "DM" : "IF");
        end
        ng++;
      end
      if (k == 2) begin
        vectors++;
        if ({if_gnt, dm_rvalid} !== 2'b11) begin
          miscompares++;
          $display("FAIL contention zero_bubble got if_gnt=%b dm_rvalid=%b exp 1 1", if_gnt, dm_rvalid);
        end
      end
      model_commit();
      @(posedge clk); #1;
    end
    vectors++;
    if (ng !== 6) begin
      miscompares++;
      $display("FAIL contention grant_count got=%0d exp=6", ng);
    end
  endtask

  task automatic test_store_ack();
    for (int k = 0; k < 7; k++) begin
      set_idle();
      if (k < 3)      begin dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; end
      else if (k < 6) begin dm_req = 1'b1; dm_addr = 32'h100; end
      model_eval();
      @(negedge clk);
      vectors++;
      if (obs_flags() !== e_flags || obs_data() !== e_data) begin
        miscompares++;
        $display("FAIL store model k=%0d got=%b/%h exp=%b/%h", k, obs_flags(), obs_data(), e_flags, e_data);
      end
      if (k == 0) begin
        vectors++;
        if ({dm_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 32'h100, 32'hDEAD_BEEF}) begin
          miscompares++;
          $display("FAIL store grant got gnt=%b en=%b we=%b addr=%h wdata=%h exp 1 1 1 00000100 deadbeef",
                   dm_gnt, mem_en, mem_we, mem_addr, mem_wdata);
        end
      end
      if (k == 2 || k == 5) begin
        vectors++;
        if ({dm_rvalid, dm_rdata} !== {1'b1, (k == 2) ? 32'h0 : 32'hDEAD_BEEF}) begin
          miscompares++;
          $display("FAIL store response k=%0d got rvalid=%b rdata=%h", k, dm_rvalid, dm_rdata);
        end
      end
      model_commit();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_dropped();
    for (int k = 0; k < 6; k++) begin
      set_idle();
      if (k == 0)     begin if_req = 1'b1; if_addr = 32'h44; end
      else if (k < 5) begin dm_req = 1'b1; dm_addr = 32'h48; end
      model_eval();
      @(negedge clk);
      vectors++;
      if (obs_flags() !== e_flags || obs_data() !== e_data) begin
        miscompares++;
        $display("FAIL dropped model k=%0d got=%b/%h exp=%b/%h", k, obs_flags(), obs_data(), e_flags, e_data);
      end
      if (k == 2) begin
        vectors++;
        if ({if_rvalid, dm_gnt, if_rdata} !== {2'b11, init_val(8'd17)}) begin
          miscompares++;
          $display("FAIL dropped rvalid_and_dm_gnt got rvalid=%b dm_gnt=%b rdata=%h exp 1 1 %h",
                   if_rvalid, dm_gnt, if_rdata, init_val(8'd17));
        end
      end
      model_commit();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    logic        if_act = 1'b0, dm_act = 1'b0, dwe = 1'b0;
    logic [31:0] ia = 32'h0, da = 32'h0, dw = 32'h0;
    for (int k = 0; k < 400; k++) begin
      if (!if_act && $urandom_range(0, 1) == 1) begin
        if_act = 1'b1;
        ia = $urandom & 32'hFFFF_FC3C;
      end
      if (!dm_act && $urandom_range(0, 1) == 1) begin
        dm_act = 1'b1;
        da  = $urandom & 32'hFFFF_FC3C;
        dw  = $urandom;
        dwe = 1'($urandom_range(0, 1));
      end
      if_req   = if_act;
      if_addr  = if_act ? ia : $urandom;
      dm_req   = dm_act;
      dm_addr  = dm_act ? da : $urandom;
      dm_wdata = dm_act ? dw : $urandom;
      dm_we    = dm_act ? dwe : 1'($urandom_range(0, 1));
      model_eval();
      @(negedge clk);
      vectors++;
      if (obs_flags() !== e_flags) begin
        miscompares++;
        $display("FAIL random flags k=%0d got=%b exp=%b", k, obs_flags(), e_flags);
      end
      vectors++;
      if (obs_data() !== e_data) begin
        miscompares++;
        $display("FAIL random data k=%0d got=%h exp=%h", k, obs_data(), e_data);
      end
      if (e_flags[3]) if_act = 1'b0;
      if (e_flags[2]) dm_act = 1'b0;
      model_commit();
      @(posedge clk); #1;
    end
  endtask

  initial begin
    clrn = 1'b0;
    env_rst_n = 1'b0;
    set_idle();
    for (int i = 0; i < 256; i++) model_mem[i] = init_val(8'(i));
    m_busy = 1'b0; m_dm = 1'b0; m_last_dm = 1'b0; m_data = 32'h0; m_done = 0; cyc = 0;
    e_flags = 8'h0; e_data = 128'h0;
    #1 env_rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_single_fetch();
    test_contention();
    test_store_ack();
    test_dropped();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
